// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier controller.
package mul_pkg;

  localparam int ITER_W_DEF = 16;

  localparam logic OPSEL_A = 1'b0;
  localparam logic OPSEL_B = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Control FSM for the repeated-addition multiplier: start/done handshake, operand
// bus steering, accumulate strobes until B reaches zero, and an iteration watchdog.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int ITER_W   = ITER_W_DEF,
  parameter int MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              eqz,
  output logic              opsel,
  output logic              LdA,
  output logic              LdB,
  output logic              clrP,
  output logic              LdP,
  output logic              decB,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

  state_t            state_r;
  logic [ITER_W-1:0] iter_r;
  logic              err_r;
  logic              acc_go_s;

  // A strobe cycle needs no cancel, a nonzero B and headroom under the watchdog.
  assign acc_go_s = (state_r == S_ACC) && !abort && !eqz && (iter_r != MAX_CNT);

  // State, iteration counter and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      iter_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r <= S_LDA;
            err_r   <= 1'b0;
          end
        end
        S_LDA:  state_r <= abort ? S_IDLE : S_LDB;
        S_LDB: begin
          if (abort) begin
            state_r <= S_IDLE;
          end else begin
            iter_r  <= '0;
            state_r <= S_ACC;
          end
        end
        S_ACC: begin
          if (abort) begin
            state_r <= S_IDLE;
          end else if (eqz) begin
            state_r <= S_DONE;
          end else if (iter_r == MAX_CNT) begin
            state_r <= S_ERR;
          end else begin
            iter_r <= iter_r + ITER_W'(1);
          end
        end
        S_DONE: state_r <= S_IDLE;
        S_ERR: begin
          err_r   <= 1'b1;
          state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Control strobes decoded from the state register; load strobes drop on abort.
  always_comb begin
    opsel = OPSEL_A;
    LdA   = 1'b0;
    LdB   = 1'b0;
    clrP  = 1'b0;
    LdP   = 1'b0;
    decB  = 1'b0;
    done  = 1'b0;
    case (state_r)
      S_LDA: LdA = !abort;
      S_LDB: begin
        LdB   = !abort;
        clrP  = !abort;
        opsel = OPSEL_B;
      end
      S_ACC: begin
        opsel = OPSEL_B;
        LdP   = acc_go_s;
        decB  = acc_go_s;
      end
      S_DONE:  done = 1'b1;
      default: opsel = OPSEL_A;
    endcase
  end

  assign busy     = (state_r != S_IDLE);
  assign err      = err_r;
  assign iter_cnt = iter_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl with a small multiplier datapath model.
module tb_mul_seq_ctrl;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int abort_cyc;
    int exp_p;
    int exp_iter;
    int exp_done;
    int exp_err;
    int exp_nldp;
  } vec_t;

  typedef struct {
    int lda_cyc;
    int ldb_cyc;
    int n_lda;
    int n_ldp;
    int ldp_win;
    int done_cyc;
    int n_done;
    int excl_bad;
    int ended;
    int p;
    int iter;
    int err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic sel = 1'b0;
  logic [15:0] a_val = 16'd0;
  logic [15:0] b_val = 16'd0;
  int checks = 0;
  int errors = 0;

  logic eqz;
  logic u0_opsel, u0_lda, u0_ldb, u0_clrp, u0_ldp, u0_decb, u0_busy, u0_done, u0_err;
  logic u1_opsel, u1_lda, u1_ldb, u1_clrp, u1_ldp, u1_decb, u1_busy, u1_done, u1_err;
  logic [15:0] u0_iter, u1_iter;
  logic m_opsel, m_lda, m_ldb, m_clrp, m_ldp, m_decb, m_busy, m_done, m_err;
  logic [15:0] m_iter;
  logic [15:0] a_reg, b_reg, data_in;
  logic [31:0] p_reg;

  always #5 clk = ~clk;

  mul_seq_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .start(start & !sel), .abort(abort & !sel), .eqz(eqz),
    .opsel(u0_opsel), .LdA(u0_lda), .LdB(u0_ldb), .clrP(u0_clrp), .LdP(u0_ldp),
    .decB(u0_decb), .busy(u0_busy), .done(u0_done), .err(u0_err), .iter_cnt(u0_iter)
  );

  mul_seq_ctrl #(.MAX_ITER(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel), .eqz(eqz),
    .opsel(u1_opsel), .LdA(u1_lda), .LdB(u1_ldb), .clrP(u1_clrp), .LdP(u1_ldp),
    .decB(u1_decb), .busy(u1_busy), .done(u1_done), .err(u1_err), .iter_cnt(u1_iter)
  );

  assign {m_opsel, m_lda, m_ldb, m_clrp, m_ldp, m_decb, m_busy, m_done, m_err} = sel ?
    {u1_opsel, u1_lda, u1_ldb, u1_clrp, u1_ldp, u1_decb, u1_busy, u1_done, u1_err} :
    {u0_opsel, u0_lda, u0_ldb, u0_clrp, u0_ldp, u0_decb, u0_busy, u0_done, u0_err};
  assign m_iter  = sel ? u1_iter : u0_iter;

  // Datapath: requester drives the operand chosen by opsel; eqz flags B==0.
  assign data_in = m_opsel ? b_val : a_val;
  assign eqz     = (b_reg == 16'd0);

  always @(posedge clk) begin
    if (m_lda) a_reg <= data_in;
    if (m_ldb) b_reg <= data_in;
    else if (m_decb) b_reg <= b_reg - 16'd1;
    if (m_clrp) p_reg <= 32'd0;
    else if (m_ldp) p_reg <= p_reg + {16'd0, a_reg};
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outcome of one operation from the timing rules and plain arithmetic.
  function automatic vec_t model(input logic [15:0] a, input logic [15:0] b,
                                 input int abort_cyc, input int max_iter);
    vec_t v;
    int n;
    v.a = a; v.b = b; v.abort_cyc = abort_cyc;
    n = (int'(b) > max_iter) ? max_iter : int'(b);
    if (abort_cyc >= 3 && abort_cyc <= 3 + n) begin
      v.exp_nldp = abort_cyc - 3;
      v.exp_done = -1;
      v.exp_err  = 0;
    end else begin
      v.exp_nldp = n;
      v.exp_done = (int'(b) <= max_iter) ? int'(b) + 4 : -1;
      v.exp_err  = (int'(b) > max_iter) ? 1 : 0;
    end
    v.exp_iter = v.exp_nldp;
    v.exp_p    = int'(a) * v.exp_nldp;
    return v;
  endfunction

  // Cycle 0 is the idle cycle in which start is first presented.
  task automatic run_op(input vec_t v, input logic [63:0] start_mask, input int limit,
                        output res_t r);
    r = '{lda_cyc: -1, ldb_cyc: -1, done_cyc: -1, default: 0};
    @(posedge clk); #1;
    a_val = v.a; b_val = v.b;
    for (int k = 0; k <= limit; k++) begin
      start = (k < 64) ? start_mask[k] : start_mask[63];
      abort = (k == v.abort_cyc);
      #2;
      if (m_lda) begin r.n_lda++; r.lda_cyc = k; end
      if (m_ldb) r.ldb_cyc = k;
      if (m_ldp) begin
        r.n_ldp++;
        if (k >= 3 && k < 3 + v.exp_nldp) r.ldp_win++;
      end
      if (m_done) begin r.n_done++; r.done_cyc = k; end
      if ((int'(m_lda) + int'(m_ldb) + int'(m_ldp)) > 1 || m_decb != m_ldp || m_clrp != m_ldb)
        r.excl_bad++;
      if (k >= 2 && !m_busy) begin
        r.ended = 1;
        break;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    r.p = int'(p_reg); r.iter = int'(m_iter); r.err = int'(m_err);
  endtask

  task automatic check_run(input string tag, input vec_t v, input res_t r);
    chk({tag, ".ended"}, r.ended, 1);
    chk({tag, ".lda_cyc"}, r.lda_cyc * 10 + r.n_lda, 11);
    chk({tag, ".ldb_cyc"}, r.ldb_cyc, 2);
    chk({tag, ".n_ldp"}, r.n_ldp, v.exp_nldp);
    chk({tag, ".ldp_window"}, r.ldp_win, v.exp_nldp);
    chk({tag, ".done_cyc"}, r.done_cyc, v.exp_done);
    chk({tag, ".n_done"}, r.n_done, (v.exp_done >= 0) ? 1 : 0);
    chk({tag, ".strobe_excl"}, r.excl_bad, 0);
    chk({tag, ".p"}, r.p, v.exp_p);
    chk({tag, ".iter"}, r.iter, v.exp_iter);
    chk({tag, ".err"}, r.err, v.exp_err);
  endtask

  vec_t tbl[12];
  vec_t v;
  res_t r;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Hand-derived cases, then randomized ones scored by the model.
    tbl[0] = '{a: 16'd5,   b: 16'd3,  abort_cyc: -1, exp_p: 15,   exp_iter: 3,  exp_done: 7,  exp_err: 0, exp_nldp: 3};
    tbl[1] = '{a: 16'd7,   b: 16'd0,  abort_cyc: -1, exp_p: 0,    exp_iter: 0,  exp_done: 4,  exp_err: 0, exp_nldp: 0};
    tbl[2] = '{a: 16'd3,   b: 16'd6,  abort_cyc: 5,  exp_p: 6,    exp_iter: 2,  exp_done: -1, exp_err: 0, exp_nldp: 2};
    tbl[3] = '{a: 16'd255, b: 16'd12, abort_cyc: -1, exp_p: 3060, exp_iter: 12, exp_done: 16, exp_err: 0, exp_nldp: 12};
    for (int i = 4; i < 12; i++) begin
      logic [15:0] ra, rb;
      int ab;
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 12));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 3 + int'(rb))) : -1;
      tbl[i] = model(ra, rb, ab, 65535);
    end

    #12;
    chk("reset.outputs", int'({u0_opsel, u0_lda, u0_ldb, u0_clrp, u0_ldp, u0_decb,
                                u0_busy, u0_done, u0_err}), 0);
    chk("reset.iter", int'(u0_iter), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i], 64'h1, int'(tbl[i].b) + 10, r);
      check_run($sformatf("vec%0d", i), tbl[i], r);
    end

    // Start pulses while busy are ignored.
    v = model(16'd2, 16'd4, -1, 65535);
    run_op(v, 64'h29, 14, r);
    check_run("start_pulses", v, r);
    // Start held through done: new LdA once idle samples start again.
    run_op(v, {64{1'b1}}, 14, r);
    check_run("start_held", v, r);
    @(posedge clk); #1; start = 1'b0;
    #2;
    chk("held.lda_next", int'(m_lda), 1);
    chk("held.busy", int'(m_busy), 1);
    abort = 1'b1; #1;
    chk("abort_lda.gated", int'(m_lda), 0);
    @(posedge clk); #1; abort = 1'b0; #2;
    chk("abort_lda.idle", int'(m_busy), 0);

    // Watchdog with a limit of four strobes, then recovery.
    sel = 1'b1;
    v = model(16'd1, 16'd10, -1, 4);
    run_op(v, 64'h1, 20, r);
    check_run("watchdog", v, r);
    v = model(16'd2, 16'd1, -1, 4);
    run_op(v, 64'h1, 20, r);
    check_run("wd_recover", v, r);
    sel = 1'b0;

    // Asynchronous reset in the middle of accumulation.
    @(posedge clk); #1;
    a_val = 16'd3; b_val = 16'd50; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("rst_mid.ldp_before", int'(u0_ldp), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid.outputs", int'({u0_opsel, u0_lda, u0_ldb, u0_clrp, u0_ldp, u0_decb,
                                  u0_busy, u0_done, u0_err}), 0);
    chk("rst_mid.iter", int'(u0_iter), 0);
    #2 rst_n = 1'b1;
    v = model(16'd9, 16'd2, -1, 65535);
    run_op(v, 64'h1, 12, r);
    check_run("after_reset", v, r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
